freq_range_ctrl: RTL

FREQ_RANGE_CTRL -- requirements
Module: freq_range_ctrl

---
 rtl/freq_range_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/freq_range_ctrl.sv
// rtl/freq_range_ctrl.sv - gated frequency-counter controller with manual or auto gate ranging
module freq_range_ctrl #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 23,
  parameter int UP_TH  = 8_000_000,
  parameter int LO_TH  = 700_000,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             auto_rng,
  input  logic [1:0]       man_range,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_ovf,
  output logic             gate_en,
  output logic             cnt_clr,
  output logic [32:0]      freq_hz,
  output logic [1:0]       range,
  output logic             valid,
  output logic             over,
  output logic             busy
);

  // Timer must hold CLK_HZ-1 (the longest gate) with a spare bit of headroom.
  localparam int TW = $clog2(CLK_HZ) + 1;

  // Timers count down from length-1 to 0 so each phase lasts exactly its length.
  localparam logic [TW-1:0] G0_LAST  = TW'(CLK_HZ - 1);
  localparam logic [TW-1:0] G1_LAST  = TW'(CLK_HZ / 10 - 1);
  localparam logic [TW-1:0] G2_LAST  = TW'(CLK_HZ / 100 - 1);
  localparam logic [TW-1:0] G3_LAST  = TW'(CLK_HZ / 1000 - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] TW_ONE   = TW'(1);

  localparam logic [CNT_W-1:0] UP_C = CNT_W'(UP_TH);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_TH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_EVAL
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    rng, rng_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          load_res;
  logic          too_high;
  logic          too_low;
  logic [32:0]   cnt_ext;
  logic [32:0]   scaled;

  // A saturated counter always counts as "too fast"; "too slow" requires a trustworthy count.
  assign too_high = cnt_ovf || (cnt_in > UP_C);
  assign too_low  = !cnt_ovf && (cnt_in < LO_C);
  assign cnt_ext  = 33'(cnt_in);

  // Scale the raw count by 10^r into Hz; the 33-bit product covers a full 23-bit count at r=3.
  always_comb begin
    scaled = cnt_ext;
    case (rng)
      2'd0:    scaled = cnt_ext;
      2'd1:    scaled = cnt_ext * 33'd10;
      2'd2:    scaled = cnt_ext * 33'd100;
      default: scaled = cnt_ext * 33'd1000;
    endcase
  end

  // Next-state, range stepping, phase timer and decoded strobes.
  always_comb begin
    state_nxt = state;
    rng_nxt   = rng;
    timer_nxt = timer;
    load_res  = 1'b0;
    gate_en   = 1'b0;
    cnt_clr   = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_CLEAR;
          rng_nxt   = man_range;
        end
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
        case (rng)
          2'd0:    timer_nxt = G0_LAST;
          2'd1:    timer_nxt = G1_LAST;
          2'd2:    timer_nxt = G2_LAST;
          default: timer_nxt = G3_LAST;
        endcase
        state_nxt = ST_GATE;
      end
      ST_GATE: begin
        gate_en = 1'b1;
        if (timer == '0) begin
          timer_nxt = SET_LAST;
          state_nxt = ST_SETTLE;
        end else begin
          timer_nxt = timer - TW_ONE;
        end
      end
      ST_SETTLE: begin
        if (timer == '0) begin
          state_nxt = ST_EVAL;
        end else begin
          timer_nxt = timer - TW_ONE;
        end
      end
      ST_EVAL: begin
        timer_nxt = '0;
        if (auto_rng && too_high && (rng != 2'd3)) begin
          // Discarded pass: retry immediately even if run dropped, the measurement is unfinished.
          rng_nxt   = rng + 2'd1;
          state_nxt = ST_CLEAR;
        end else if (auto_rng && too_low && (rng != 2'd0)) begin
          rng_nxt   = rng - 2'd1;
          state_nxt = ST_CLEAR;
        end else begin
          load_res = 1'b1;
          if (run) begin
            state_nxt = ST_CLEAR;
            if (!auto_rng) begin
              rng_nxt = man_range;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      rng   <= 2'd0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      rng   <= rng_nxt;
      timer <= timer_nxt;
    end
  end

  // Result registers load only on an accepted EVAL and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_hz <= '0;
      range   <= 2'd0;
      over    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= load_res;
      if (load_res) begin
        freq_hz <= scaled;
        range   <= rng;
        over    <= (rng == 2'd3) && too_high;
      end
    end
  end

endmodule
